text_console_ctrl: RTL and testbench
====================================

// Module: text_console_ctrl
// PURPOSE
//  Turns a byte stream into text on the 100x30 HDMI text display.
//  Owns the VRAM write port and the display configuration (top_row, cursor_row, cursor_col).
//  Handles printable chars, CR, LF, BS and FF. Scrolls by advancing top_row and blanking the
//  recycled row. Sits between the terminal/UART source and the VRAM + hdmi display path.
// PARAMETERS
//  COLS   100   characters per row (col index 0..COLS-1, 7-bit)
//  ROWS   30    rows in VRAM ring (row index 0..ROWS-1, 5-bit)
//  BLANK  8'h20 byte written when clearing
// PORTS
//  clk           in   1  pixel clock, single clock domain
//  reset_low     in   1  asynchronous, active-low reset
//  in_valid      in   1  source byte valid
//  in_ready      out  1  block can accept a byte this cycle
//  in_byte       in   8  source byte
//  vram_we       out  1  VRAM write strobe, one write per cycle
//  vram_wr_row   out  5  physical VRAM row of write
//  vram_wr_col   out  7  column of write
//  vram_wr_byte  out  8  data of write
//  top_row       out  5  physical row shown at screen top (to display)
//  cursor_row    out  5  physical VRAM row of cursor (to display)
//  cursor_col    out  7  cursor column (to display)
// BEHAVIOUR
//  Reset: every output is 0, including in_ready, vram_we and all row/col/byte outputs; state <= CLR_ALL.
//  Deassertion: clearing starts on the first clk edge after reset_low deasserts.
//  States:
//   CLR_ALL  writes BLANK to every cell, row-major (r0c0, r0c1, ... r29c99), one per cycle.
//            Takes ROWS*COLS = 3000 cycles, then IDLE.
//   IDLE     in_ready = 1; a byte is accepted on in_valid & in_ready.
//   CLR_ROW  writes BLANK to cols 0..COLS-1 of clr_row, one per cycle; COLS cycles, then IDLE.
//  in_ready is 0 in CLR_ALL and CLR_ROW; it deasserts the cycle after an accept that enters
//   either state.
//  All outputs are registered.
//   A write for an accepted byte appears on vram_* one cycle after the accept edge.
//   Cursor and top_row update on the same edge as that write.
//  Accepted byte handling (row ops are mod ROWS, with explicit compare, not a power of 2):
//   0x20..0x7E  write byte at (cursor_row, cursor_col).
//               If cursor_col < COLS-1: cursor_col+1.
//               Else: cursor_col = 0, then LINE_FEED.
//   0x0A LF     cursor_col = 0, then LINE_FEED.
//   0x0D CR     cursor_col = 0.
//   0x08 BS     if cursor_col > 0: cursor_col-1; else no change; no erase.
//   0x0C FF     top_row = 0, cursor = (0,0), enter CLR_ALL.
//   other       consumed, no effect.
//  LINE_FEED:
//   nr = (cursor_row == ROWS-1) ? 0 : cursor_row+1; cursor_row = nr.
//   If nr == top_row (cursor was on the bottom screen line):
//    top_row = top_row+1 mod ROWS, clr_row = nr, enter CLR_ROW.
//  Printable at col COLS-1 on the bottom line: char write, then scroll and clear, in that order.
//  During CLR_ROW the cursor sits at (clr_row, 0); the display may show the stale row until
//   it is cleared (accepted artefact, max COLS cycles).
//  Counters: CLR_ALL row/col counters wrap col at COLS-1 -> 0 with row+1;
//   the last write is (ROWS-1, COLS-1).
//  Async reset mid-CLR_ROW/CLR_ALL aborts it and restarts CLR_ALL from (0,0).
//  No VRAM read port, no arbitration: the display owns the read port, this block owns the write port.
// TESTING
//  1 Reset then release -> exactly 3000 vram_we pulses of 0x20 in row-major order.
//    in_ready rises on the cycle after the (29,99) write. top_row = 0, cursor = (0,0).
//  2 Send 'A' (0x41) -> next cycle: vram_we=1, (0,0,0x41), cursor_col=1; in_ready stays 1.
//  3 Send 100 x 'x' -> last write at (0,99); cursor = (1,0); no clear, in_ready never drops.
//  4 Cursor on row 29, top_row=0; send LF -> top_row=1, cursor=(0,0).
//    Then 100 writes of 0x20 to row 0, cols 0..99; in_ready low for exactly 100 cycles.
//  5 Send CR, BS, BS at cursor (3,1) -> cursor (3,0) after CR; BS leaves it at (3,0);
//    no vram_we for any of them.
//  6 Send FF with top_row=7 -> top_row=0, cursor=(0,0), full 3000-write clear.
//    Assert reset_low low mid-clear -> outputs 0 at once; clear restarts from (0,0).

Source files
------------

// File: rtl/text_console_ctrl.sv
// Byte-stream text console: owns the VRAM write port and cursor/scroll state of a COLSxROWS
// ring-buffered text screen. Handles printable chars, CR, LF, BS, FF, and row-recycling scroll.
module text_console_ctrl #(
    parameter int unsigned COLS  = 100,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       vram_we,
    output logic [4:0] vram_wr_row,
    output logic [6:0] vram_wr_col,
    output logic [7:0] vram_wr_byte,
    output logic [4:0] top_row,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col
);

    localparam logic [6:0] LastCol = 7'(COLS - 1);
    localparam logic [4:0] LastRow = 5'(ROWS - 1);

    typedef enum logic [1:0] {StClrAll, StIdle, StClrRow} state_t;

    state_t     r_state;
    logic       r_in_ready;
    logic       r_vram_we;
    logic [4:0] r_vram_wr_row;
    logic [6:0] r_vram_wr_col;
    logic [7:0] r_vram_wr_byte;
    logic [4:0] r_top_row;
    logic [4:0] r_cursor_row;
    logic [6:0] r_cursor_col;
    logic [4:0] r_cnt_row;
    logic [6:0] r_cnt_col;
    logic [4:0] r_clr_row;
    logic [6:0] r_clr_col;

    logic       w_accept;
    logic       w_printable;
    logic [4:0] w_next_row;
    logic [4:0] w_next_top;
    logic       w_scroll;

    // r_in_ready is only ever high in StIdle, so it doubles as the accept qualifier.
    assign w_accept    = r_in_ready & in_valid;
    assign w_printable = (in_byte >= 8'h20) && (in_byte <= 8'h7E);
    assign w_next_row  = (r_cursor_row == LastRow) ? 5'd0 : r_cursor_row + 5'd1;
    assign w_next_top  = (r_top_row == LastRow) ? 5'd0 : r_top_row + 5'd1;
    assign w_scroll    = (w_next_row == r_top_row);

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_state        <= StClrAll;
            r_in_ready     <= 1'b0;
            r_vram_we      <= 1'b0;
            r_vram_wr_row  <= 5'd0;
            r_vram_wr_col  <= 7'd0;
            r_vram_wr_byte <= 8'd0;
            r_top_row      <= 5'd0;
            r_cursor_row   <= 5'd0;
            r_cursor_col   <= 7'd0;
            r_cnt_row      <= 5'd0;
            r_cnt_col      <= 7'd0;
            r_clr_row      <= 5'd0;
            r_clr_col      <= 7'd0;
        end else begin
            r_vram_we <= 1'b0;
            case (r_state)
                StClrAll: begin
                    r_in_ready     <= 1'b0;
                    r_vram_we      <= 1'b1;
                    r_vram_wr_row  <= r_cnt_row;
                    r_vram_wr_col  <= r_cnt_col;
                    r_vram_wr_byte <= BLANK;
                    if (r_cnt_col == LastCol) begin
                        r_cnt_col <= 7'd0;
                        if (r_cnt_row == LastRow) begin
                            r_cnt_row <= 5'd0;
                            r_state   <= StIdle;
                        end else begin
                            r_cnt_row <= r_cnt_row + 5'd1;
                        end
                    end else begin
                        r_cnt_col <= r_cnt_col + 7'd1;
                    end
                end
                StClrRow: begin
                    r_in_ready     <= 1'b0;
                    r_vram_we      <= 1'b1;
                    r_vram_wr_row  <= r_clr_row;
                    r_vram_wr_col  <= r_clr_col;
                    r_vram_wr_byte <= BLANK;
                    if (r_clr_col == LastCol) begin
                        r_clr_col <= 7'd0;
                        r_state   <= StIdle;
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end
                StIdle: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_printable) begin
                            r_vram_we      <= 1'b1;
                            r_vram_wr_row  <= r_cursor_row;
                            r_vram_wr_col  <= r_cursor_col;
                            r_vram_wr_byte <= in_byte;
                            if (r_cursor_col < LastCol) begin
                                r_cursor_col <= r_cursor_col + 7'd1;
                            end else begin
                                r_cursor_col <= 7'd0;
                                r_cursor_row <= w_next_row;
                                if (w_scroll) begin
                                    r_top_row  <= w_next_top;
                                    r_clr_row  <= w_next_row;
                                    r_clr_col  <= 7'd0;
                                    r_state    <= StClrRow;
                                    r_in_ready <= 1'b0;
                                end
                            end
                        end else if (in_byte == 8'h0A) begin
                            r_cursor_col <= 7'd0;
                            r_cursor_row <= w_next_row;
                            if (w_scroll) begin
                                // No char write pending, so column 0 is blanked on this edge.
                                r_top_row      <= w_next_top;
                                r_clr_row      <= w_next_row;
                                r_clr_col      <= 7'd1;
                                r_vram_we      <= 1'b1;
                                r_vram_wr_row  <= w_next_row;
                                r_vram_wr_col  <= 7'd0;
                                r_vram_wr_byte <= BLANK;
                                r_state        <= StClrRow;
                                r_in_ready     <= 1'b0;
                            end
                        end else if (in_byte == 8'h0D) begin
                            r_cursor_col <= 7'd0;
                        end else if (in_byte == 8'h08) begin
                            if (r_cursor_col != 7'd0) r_cursor_col <= r_cursor_col - 7'd1;
                        end else if (in_byte == 8'h0C) begin
                            r_top_row    <= 5'd0;
                            r_cursor_row <= 5'd0;
                            r_cursor_col <= 7'd0;
                            r_cnt_row    <= 5'd0;
                            r_cnt_col    <= 7'd0;
                            r_state      <= StClrAll;
                            r_in_ready   <= 1'b0;
                        end
                    end
                end
                default: r_state <= StClrAll;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign vram_we      = r_vram_we;
    assign vram_wr_row  = r_vram_wr_row;
    assign vram_wr_col  = r_vram_wr_col;
    assign vram_wr_byte = r_vram_wr_byte;
    assign top_row      = r_top_row;
    assign cursor_row   = r_cursor_row;
    assign cursor_col   = r_cursor_col;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: clears, printing, control bytes, scroll and FF/reset.
module tb_text_console_ctrl;

    logic       clk;
    logic       reset_low;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       vram_we;
    logic [4:0] vram_wr_row;
    logic [6:0] vram_wr_col;
    logic [7:0] vram_wr_byte;
    logic [4:0] top_row;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;

    int n_checks = 0;
    int n_fail   = 0;

    text_console_ctrl dut (
        .clk          (clk),
        .reset_low    (reset_low),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .vram_we      (vram_we),
        .vram_wr_row  (vram_wr_row),
        .vram_wr_col  (vram_wr_col),
        .vram_wr_byte (vram_wr_byte),
        .top_row      (top_row),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {25'd0, in_ready, vram_we, vram_wr_row, vram_wr_col, vram_wr_byte,
                top_row, cursor_row, cursor_col};
    endfunction

    // Presents one byte at a negedge; returns on the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk);
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Watches a clear from the current sample until in_ready rises.
    task automatic run_clear(input string tag, input bit full, input int row, input int exp_low);
        int writes = 0;
        int bad    = 0;
        int low    = 0;
        int er, ec;
        for (int i = 0; i < 3300; i++) begin
            if (i > 0) @(negedge clk);
            if (in_ready) break;
            low++;
            if (vram_we) begin
                er = full ? writes / 100 : row;
                ec = full ? writes % 100 : writes;
                if (int'(vram_wr_row) != er || int'(vram_wr_col) != ec || vram_wr_byte != 8'h20)
                    bad++;
                writes++;
            end
        end
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_writes"}, 64'(writes), full ? 64'd3000 : 64'd100);
        chk({tag, "_order"}, 64'(bad), 64'd0);
        if (exp_low >= 0) chk({tag, "_low"}, 64'(low), 64'(exp_low));
    endtask

    initial begin
        reset_low = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 64'd0);
        reset_low = 1'b1;
        run_clear("init_clr", 1'b1, 0, 3001);
        chk("init_idle", {top_row, cursor_row, cursor_col, vram_we}, 64'd0);

        send(8'h41);
        chk("a_write", {vram_we, vram_wr_row, vram_wr_col, vram_wr_byte}, {1'b1, 5'd0, 7'd0, 8'h41});
        chk("a_cursor", {cursor_row, cursor_col, in_ready}, {5'd0, 7'd1, 1'b1});

        send(8'h0D);
        chk("cr_home", {vram_we, cursor_row, cursor_col}, {1'b0, 5'd0, 7'd0});
        begin
            int drops = 0;
            for (int i = 0; i < 100; i++) begin
                send(8'h78);
                if (!in_ready) drops++;
            end
            chk("x100_ready", 64'(drops), 64'd0);
        end
        chk("x100_last", {vram_we, vram_wr_row, vram_wr_col, vram_wr_byte}, {1'b1, 5'd0, 7'd99, 8'h78});
        chk("x100_cursor", {top_row, cursor_row, cursor_col}, {5'd0, 5'd1, 7'd0});

        send(8'h0A);
        send(8'h0A);
        send(8'h62);
        chk("b_cursor", {cursor_row, cursor_col}, {5'd3, 7'd1});
        send(8'h0D);
        chk("cr_31", {vram_we, cursor_row, cursor_col}, {1'b0, 5'd3, 7'd0});
        send(8'h08);
        chk("bs_1", {vram_we, cursor_row, cursor_col}, {1'b0, 5'd3, 7'd0});
        send(8'h08);
        chk("bs_2", {vram_we, cursor_row, cursor_col}, {1'b0, 5'd3, 7'd0});
        send(8'h07);
        chk("other_byte", {vram_we, cursor_row, cursor_col, in_ready}, {1'b0, 5'd3, 7'd0, 1'b1});

        for (int i = 0; i < 26; i++) send(8'h0A);
        chk("row29", {top_row, cursor_row, cursor_col}, {5'd0, 5'd29, 7'd0});
        send(8'h0A);
        chk("lf_scroll", {top_row, cursor_row, cursor_col}, {5'd1, 5'd0, 7'd0});
        run_clear("lf_clr", 1'b0, 0, 100);

        // Printable at the last column of the bottom line: char first, then scroll.
        for (int i = 0; i < 99; i++) send(8'h79);
        chk("y99_cursor", {cursor_row, cursor_col}, {5'd0, 7'd99});
        send(8'h7A);
        chk("wrap_write", {vram_we, vram_wr_row, vram_wr_col, vram_wr_byte}, {1'b1, 5'd0, 7'd99, 8'h7A});
        chk("wrap_scroll", {top_row, cursor_row, cursor_col, in_ready}, {5'd2, 5'd1, 7'd0, 1'b0});
        @(negedge clk);
        run_clear("wrap_clr", 1'b0, 1, 100);

        for (int i = 0; i < 5; i++) send(8'h0A);
        chk("top7", {top_row, cursor_row}, {5'd7, 5'd6});
        for (int i = 0; i < 400 && !in_ready; i++) @(negedge clk);
        send(8'h0C);
        chk("ff_state", {top_row, cursor_row, cursor_col, vram_we, in_ready}, 64'd0);
        repeat (1000) @(negedge clk);
        chk("ff_mid", {vram_we, vram_wr_row, vram_wr_col, in_ready}, {1'b1, 5'd9, 7'd99, 1'b0});
        reset_low = 1'b0;
        #1;
        chk("midclr_reset", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_low = 1'b1;
        run_clear("restart_clr", 1'b1, 0, 3001);
        chk("final_pos", {top_row, cursor_row, cursor_col}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
